multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM that sequences a multi-cycle RV32I core.
- The core has one shared ALU, one unified instruction/data memory port, and one register file.
- The block decodes the latched instruction and steps through fetch/decode/execute/memory/writeback states.
- It drives all datapath enables and mux selects, and stalls on the memory ready handshake.

Parameters:
- RESET_STATE_FETCH, 1, when 1 the FSM leaves reset in FETCH; when 0 it leaves reset in a one-cycle IDLE state first.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- instr  in  32  instruction register contents (valid from DECODE onward)
- eq  in  1  ALU equality flag (rs1 == rs2)
- mem_ready  in  1  memory handshake; access completes in the cycle it is high while mem_req is high
- mem_req  out  1  memory access request
- mem_we  out  1  memory write strobe (store)
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  instruction register and oldPC latch enable
- pc_we  out  1  PC write enable
- reg_we  out  1  register file write enable (we3)
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = ImmOp, 10 = constant 4
- result_src  out  2  result select: 00 = ALUOut, 01 = mem data, 10 = ALU result
- alu_ctrl  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  immediate format: 00 I, 01 S, 10 B
- illegal  out  1  sticky unsupported-opcode flag

Behaviour:
- Reset is asynchronous and active-high (rst). State goes to FETCH (or IDLE per parameter).
- All outputs are 0 during reset except alu_src_b = 10, which is harmless. illegal clears to 0.
- Supported opcodes:
  - 0110011 R-type: add/sub/and/or/slt. sub when funct7[5] = 1 and funct3 = 000.
  - 0010011 I-type: addi/andi/ori/slti.
  - 0000011 lw, 0100011 sw.
  - 1100011 beq (funct3 000) and bne (funct3 001).
- FETCH:
  - mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_ctrl = add, result_src = 10.
  - Hold in FETCH while mem_ready = 0; address and selects stay stable throughout.
  - On mem_ready = 1: ir_we = 1, pc_we = 1 (PC <= PC + 4), go to DECODE.
- DECODE: alu_src_a = 01, alu_src_b = 01, imm_src = 10, alu_ctrl = add. This precomputes the branch target into ALUOut. Next state by opcode:
  - lw/sw -> MEMADR
  - R -> EXEC_R
  - I -> EXEC_I
  - branch -> BRANCH
  - any other opcode -> TRAP
- MEMADR: alu_src_a = 10, alu_src_b = 01, add. imm_src = 00 for lw, 01 for sw. Next state MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req = 1, adr_src = 1. Wait for mem_ready, then go to MEMWB.
- MEMWB: reg_we = 1, result_src = 01, then go to FETCH.
- MEMWRITE: mem_req = 1, mem_we = 1, adr_src = 1. Wait for mem_ready, then go to FETCH. mem_we is never high without mem_req.
- EXEC_R: alu_src_a = 10, alu_src_b = 00, alu_ctrl from funct3/funct7, then go to ALUWB.
- EXEC_I: alu_src_a = 10, alu_src_b = 01, imm_src = 00. alu_ctrl from funct3; funct7 is ignored (addi never subtracts). Go to ALUWB.
- ALUWB: reg_we = 1, result_src = 00, then go to FETCH.
- BRANCH: alu_src_a = 10, alu_src_b = 00, alu_ctrl = sub, result_src = 00. pc_we = eq for beq, pc_we = !eq for bne. Then go to FETCH.
- TRAP: illegal <= 1 and the FSM stays in TRAP until rst. A branch with any other funct3 traps.
- Latency with mem_ready = 1 every access:
  - branch 3 cycles
  - R/I 4 cycles
  - sw 4 cycles
  - lw 5 cycles
- Memory wait states add one cycle each.
- Reset asserted mid-instruction aborts it immediately. No partial reg_we or mem_we occurs after reset.

Optional Feature:
- MULTICYCLE_CTRL_PERF_EN defined:
  - Adds output instret (32 bits), which increments by 1 on each transition into FETCH from MEMWB, ALUWB, MEMWRITE or BRANCH.
  - Adds output cycles (32 bits), which increments every cycle outside reset.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: neither port nor counter exists.

Decomposition:
- Package multicycle_pkg holds:
  - state_t enum (IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, TRAP)
  - opcode localparams
  - alu_ctrl, imm_src, alu_src and result_src encodings
- Natural sub-module: alu_decoder, which maps funct3, funct7[5] and op class to alu_ctrl (combinational).

Test Plan:
- Reset, then release; instr = 0x00500093 (addi x1,x0,5), mem_ready = 1. Expected:
  - states FETCH, DECODE, EXEC_I, ALUWB
  - reg_we = 1 only in cycle 4, with imm_src = 00 and alu_ctrl = 000
  - FETCH re-entered at cycle 5
- instr = 0x0000A103 (lw x2,0(x1)), mem_ready low for 2 cycles in MEMREAD. Expected:
  - mem_req and adr_src = 1 held stable for 3 cycles
  - reg_we with result_src = 01 one cycle later
  - 7 cycles total
- instr = 0x0020A223 (sw x2,4(x1)). Expected: imm_src = 01 in MEMADR; mem_we = mem_req = 1 in MEMWRITE; reg_we never asserted.
- instr = 0x00000463 (beq x0,x0,8):
  - with eq = 1: pc_we = 1 in BRANCH
  - with eq = 0: pc_we = 0
  - repeated with bne 0x00001463: results inverted
- instr = 0xFFFFFFFF. Expected: TRAP after DECODE, illegal = 1 held, no further mem_req. Asserting rst then clears illegal and returns the FSM to FETCH.
- rst asserted during MEMWRITE while mem_ready = 0. Expected: mem_we and mem_req drop asynchronously. With perf enabled: instret = 0 and cycles = 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package multicycle_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB,
    MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, TRAP
  } state_t;

  // Operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD, ALUOP_SUB, ALUOP_R, ALUOP_I
  } alu_op_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic branch_legal(input logic [2:0] funct3);
    return (funct3 == F3_BEQ) || (funct3 == F3_BNE);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps operation class plus funct3/funct7[5] onto the ALU control code.
module alu_decoder
  import multicycle_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_R, ALUOP_I: begin
        case (funct3)
          // Immediate forms never subtract: funct7 bits there are immediate data
          F3_ADD:  alu_ctrl = (alu_op == ALUOP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          F3_SLT:  alu_ctrl = ALU_SLT;
          F3_OR:   alu_ctrl = ALU_OR;
          F3_AND:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle RV32I core (shared ALU, unified memory port).
// Optional MULTICYCLE_CTRL_PERF_EN adds instret/cycles performance counters.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        eq,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [2:0]  alu_ctrl,
  output logic [1:0]  imm_src,
  output logic        illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] cycles
`endif
);

  localparam state_t RST_STATE = RESET_STATE_FETCH ? FETCH : IDLE;

  state_t     state;
  alu_op_t    alu_op;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7_5     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_STATE;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE:     state <= FETCH;
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXEC_R;
            OP_I:         state <= EXEC_I;
            OP_BR: begin
              if (branch_legal(funct3)) begin
                state <= BRANCH;
              end else begin
                state   <= TRAP;
                illegal <= 1'b1;
              end
            end
            default: begin
              state   <= TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        MEMADR:   state <= (opcode == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXEC_R:   state <= ALUWB;
        EXEC_I:   state <= ALUWB;
        MEMWB:    state <= FETCH;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        TRAP: begin
          state   <= TRAP;
          illegal <= 1'b1;
        end
        default: begin
          state   <= TRAP;
          illegal <= 1'b1;
        end
      endcase
    end
  end

  // Decoded from state and gated by rst so enables drop the moment reset asserts
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_FOUR;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_req    = 1'b1;
          ir_we      = mem_ready;
          pc_we      = mem_ready;
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
        end
        DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_B;
        end
        MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (opcode == OP_SW) ? IMM_S : IMM_I;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        MEMWB: begin
          reg_we     = 1'b1;
          result_src = RES_MEM;
        end
        MEMWRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = ALUOP_R;
        end
        EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_I;
          alu_op    = ALUOP_I;
        end
        ALUWB: begin
          reg_we     = 1'b1;
          result_src = RES_ALUOUT;
        end
        BRANCH: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_RS2;
          alu_op     = ALUOP_SUB;
          result_src = RES_ALUOUT;
          pc_we      = (funct3 == F3_BNE) ? !eq : eq;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_ctrl (alu_ctrl)
  );

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic retire;

  assign retire = (state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
                  ((state == MEMWRITE) && mem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
      cycles  <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (retire) instret <= instret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle control expectations derived
// from the instruction semantics, checked by an independent negedge monitor.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        eq = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, illegal;
  logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0]  alu_ctrl;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] instret, cycles;
  int          tb_cycles;
`endif

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [1:0] rs;
    logic [2:0] ac;
    logic [1:0] is;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  v;
    ctl_t  m;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   retired = 0;
  ctl_t act;

  assign act = {mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
                alu_src_a, alu_src_b, result_src, alu_ctrl, imm_src, illegal};

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .eq         (eq),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .adr_src    (adr_src),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .reg_we     (reg_we),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_ctrl   (alu_ctrl),
    .imm_src    (imm_src),
    .illegal    (illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .instret    (instret),
    .cycles     (cycles)
`endif
  );

`ifdef MULTICYCLE_CTRL_PERF_EN
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cycles <= 0;
    else     tb_cycles <= tb_cycles + 1;
  end
`endif

  // Enables and illegal are always compared; a negative select means "don't care".
  function automatic exp_t mk(input string tag, input bit mreq, input bit mwe,
                              input bit irwe, input bit pcwe, input bit regwe,
                              input int adr, input int asa, input int asb,
                              input int rs, input int ac, input int is);
    exp_t e;
    e.tag = tag;
    e.v = '0;
    e.m = '0;
    e.v.mem_req = mreq;  e.m.mem_req = 1'b1;
    e.v.mem_we  = mwe;   e.m.mem_we  = 1'b1;
    e.v.ir_we   = irwe;  e.m.ir_we   = 1'b1;
    e.v.pc_we   = pcwe;  e.m.pc_we   = 1'b1;
    e.v.reg_we  = regwe; e.m.reg_we  = 1'b1;
    e.m.illegal = 1'b1;
    if (adr >= 0) begin e.v.adr_src = adr[0];   e.m.adr_src = 1'b1; end
    if (asa >= 0) begin e.v.asa = asa[1:0];     e.m.asa = 2'b11;    end
    if (asb >= 0) begin e.v.asb = asb[1:0];     e.m.asb = 2'b11;    end
    if (rs  >= 0) begin e.v.rs  = rs[1:0];      e.m.rs  = 2'b11;    end
    if (ac  >= 0) begin e.v.ac  = ac[2:0];      e.m.ac  = 3'b111;   end
    if (is  >= 0) begin e.v.is  = is[1:0];      e.m.is  = 2'b11;    end
    return e;
  endfunction

  function automatic exp_t mk_reset();
    exp_t e;
    e.tag = "RESET";
    e.v = '0;
    e.v.asb = 2'b10;
    e.m = '1;
    return e;
  endfunction

  // ALU op implied by the instruction mnemonic
  function automatic int alu_exp(input bit rtype, input logic [2:0] f3, input bit f75);
    case (f3)
      3'b000:  return (rtype && f75) ? 1 : 0;
      3'b010:  return 5;
      3'b110:  return 3;
      3'b111:  return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [2:0]  f3s [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    imm = 12'($urandom);
    f3  = f3s[$urandom_range(0, 3)];
    f7  = (f3 == 3'b000 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    case ($urandom_range(0, 5))
      0:       return {f7, rs2, rs1, f3, rd, 7'b0110011};
      1:       return {imm, rs1, f3, rd, 7'b0010011};
      2:       return {imm, rs1, 3'b010, rd, 7'b0000011};
      3:       return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      4:       return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b1100011};
      default: return {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b1100011};
    endcase
  endfunction

  // Call at posedge+1 with the FSM in FETCH. cut > 0 drives only that many cycles.
  task automatic run_instr(input logic [31:0] ins, input bit eqv, input int wf,
                           input int wm, input int cut);
    exp_t       q[$];
    bit         mr[$];
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    bit         f75, legal, is_sw;
    int         br_idx, n;
    op     = ins[6:0];
    f3     = ins[14:12];
    f75    = ins[30];
    legal  = 1'b1;
    br_idx = -1;
    is_sw  = (op == 7'b0100011);
    for (int i = 0; i < wf; i++) begin
      q.push_back(mk("FETCH_WAIT", 1, 0, 0, 0, 0, 0, 0, 2, 2, 0, -1)); mr.push_back(1'b0);
    end
    q.push_back(mk("FETCH", 1, 0, 1, 1, 0, 0, 0, 2, 2, 0, -1)); mr.push_back(1'b1);
    q.push_back(mk("DECODE", 0, 0, 0, 0, 0, -1, 1, 1, -1, 0, 2));
    mr.push_back(1'($urandom_range(0, 1)));
    case (op)
      7'b0000011, 7'b0100011: begin
        q.push_back(mk("MEMADR", 0, 0, 0, 0, 0, -1, 2, 1, -1, 0, is_sw ? 1 : 0));
        mr.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i <= wm; i++) begin
          q.push_back(mk(is_sw ? "MEMWRITE" : "MEMREAD", 1, is_sw, 0, 0, 0, 1, -1, -1, -1, -1, -1));
          mr.push_back(i == wm);
        end
        if (!is_sw) begin
          q.push_back(mk("MEMWB", 0, 0, 0, 0, 1, -1, -1, -1, 1, -1, -1));
          mr.push_back(1'($urandom_range(0, 1)));
        end
      end
      7'b0110011, 7'b0010011: begin
        if (op == 7'b0110011)
          q.push_back(mk("EXEC_R", 0, 0, 0, 0, 0, -1, 2, 0, -1, alu_exp(1, f3, f75), -1));
        else
          q.push_back(mk("EXEC_I", 0, 0, 0, 0, 0, -1, 2, 1, -1, alu_exp(0, f3, f75), 0));
        mr.push_back(1'($urandom_range(0, 1)));
        q.push_back(mk("ALUWB", 0, 0, 0, 0, 1, -1, -1, -1, 0, -1, -1));
        mr.push_back(1'($urandom_range(0, 1)));
      end
      7'b1100011: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          br_idx = q.size();
          q.push_back(mk(f3 == 3'b000 ? "BEQ" : "BNE", 0, 0, 0,
                         (f3 == 3'b000) ? eqv : !eqv, 0, -1, 2, 0, 0, 1, -1));
          mr.push_back(1'($urandom_range(0, 1)));
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      for (int i = 0; i < 4; i++) begin
        e = mk("TRAP", 0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1);
        e.v.illegal = 1'b1;
        q.push_back(e);
        mr.push_back(1'($urandom_range(0, 1)));
      end
    end
    n = (cut > 0) ? cut : q.size();
    for (int i = 0; i < n; i++) exp_q.push_back(q[i]);
    for (int i = 0; i < n; i++) begin
      instr     = ins;
      mem_ready = mr[i];
      eq        = (i == br_idx) ? eqv : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    if (legal && cut == 0) begin
      retired++;
`ifdef MULTICYCLE_CTRL_PERF_EN
      checks++;
      if (instret !== 32'(retired)) begin
        errors++;
        $display("FAIL instret after %h: got %0d want %0d", ins, instret, retired);
      end
`endif
    end
  endtask

  // Call at posedge+1; reset is raised mid-cycle so its effect is seen before the next edge.
  task automatic do_reset(input int n);
    rst       = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(mk_reset());
    #1;
`ifdef MULTICYCLE_CTRL_PERF_EN
    checks++;
    if (instret !== 32'd0 || cycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: instret=%0d cycles=%0d want 0 0", instret, cycles);
    end
`endif
    repeat (n) @(posedge clk);
    #1;
    rst     = 1'b0;
    retired = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ((act & e.m) !== (e.v & e.m)) begin
          errors++;
          $display("FAIL %s: got %h want %h (care %h) at %0t", e.tag, act, e.v, e.m, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) exp_q.push_back(mk_reset());
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(32'h00500093, 1'b0, 0, 0, 0);   // addi x1,x0,5
    run_instr(32'h0000A103, 1'b0, 0, 2, 0);   // lw x2,0(x1) with 2 wait states
    run_instr(32'h0020A223, 1'b0, 0, 0, 0);   // sw x2,4(x1)
    run_instr(32'h00000463, 1'b1, 0, 0, 0);   // beq taken
    run_instr(32'h00000463, 1'b0, 0, 0, 0);   // beq not taken
    run_instr(32'h00001463, 1'b1, 0, 0, 0);   // bne not taken
    run_instr(32'h00001463, 1'b0, 0, 0, 0);   // bne taken
    run_instr(32'h40000033, 1'b0, 1, 0, 0);   // sub with a fetch wait
    run_instr(32'hFFF00093, 1'b0, 0, 0, 0);   // addi with imm[10]=1 must still add

    for (int k = 0; k < 60; k++)
      run_instr(rand_instr(), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2), 0);

`ifdef MULTICYCLE_CTRL_PERF_EN
    checks++;
    if (cycles !== 32'(tb_cycles)) begin
      errors++;
      $display("FAIL cycles: got %0d want %0d", cycles, tb_cycles);
    end
`endif

    run_instr(32'hFFFFFFFF, 1'b0, 0, 0, 0);   // unsupported opcode -> TRAP
    do_reset(2);
    run_instr(32'h00500093, 1'b0, 0, 0, 0);
    run_instr(32'h00002463, 1'b0, 0, 0, 0);   // branch funct3=010 -> TRAP
    do_reset(1);
    run_instr(32'h0020A223, 1'b0, 0, 5, 5);   // stall in MEMWRITE, then abort
    do_reset(2);
    run_instr(32'h0000A103, 1'b0, 1, 1, 0);
    run_instr(32'h00500093, 1'b0, 0, 0, 0);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
